// File: rtl/pe_ctrl_pkg.sv
// Shared types and default PE widths for the PE job sequencer.
package pe_ctrl_pkg;

  localparam int PE_LANES        = 4;
  localparam int PE_DATA_WIDTH   = 16;
  localparam int PE_WEIGHT_WIDTH = 4;
  localparam int PE_RESULT_WIDTH = 16;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, OUT} pe_ctrl_state_t;

endpackage

// File: rtl/PE_data_if.sv
// Operand/result bundle between a sequencer (master) and one processing element.
interface PE_data_if import pe_ctrl_pkg::*; #(
  parameter int DATA_WIDTH   = PE_DATA_WIDTH,
  parameter int WEIGHT_WIDTH = PE_WEIGHT_WIDTH,
  parameter int RESULT_WIDTH = PE_RESULT_WIDTH
);

  logic [PE_LANES-1:0][DATA_WIDTH-1:0] data_in;
  logic [WEIGHT_WIDTH-1:0]             weight_in;
  logic [RESULT_WIDTH-1:0]             result_out;

  modport pe_master (output data_in, output weight_in, input result_out);
  modport pe_slave  (input data_in, input weight_in, output result_out);

endinterface

// File: rtl/pe_valid_pipe.sv
// Valid-bit delay line: an issue pulse reappears as retire DEPTH cycles later.
module pe_valid_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  output logic retire
);

  logic [DEPTH-1:0] pipe_q;
  logic [DEPTH-1:0] pipe_d;

  always_comb begin
    pipe_d = (pipe_q << 1) | DEPTH'(issue);
  end

  always_ff @(posedge clk) begin
    if (rst) pipe_q <= '0;
    else     pipe_q <= pipe_d;
  end

  assign retire = pipe_q[DEPTH-1];

endmodule

// File: rtl/pe_seq_ctrl.sv
// Feeds a PE with len operand beats, accumulates its results and returns one sum per job.
module pe_seq_ctrl import pe_ctrl_pkg::*; #(
  parameter int DATA_WIDTH   = PE_DATA_WIDTH,
  parameter int WEIGHT_WIDTH = PE_WEIGHT_WIDTH,
  parameter int RESULT_WIDTH = PE_RESULT_WIDTH,
  parameter int ACC_WIDTH    = 24,
  parameter int LEN_WIDTH    = 8,
  parameter int PE_LATENCY   = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [LEN_WIDTH-1:0]                len,
  output logic                                busy,
  input  logic                                src_valid,
  output logic                                src_ready,
  input  logic [PE_LANES-1:0][DATA_WIDTH-1:0] src_data,
  input  logic [WEIGHT_WIDTH-1:0]             src_weight,
  PE_data_if.pe_master                        pe,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic [ACC_WIDTH-1:0]                res_data,
  output pe_ctrl_state_t                      state_dbg
);

  // Handshakes: a transfer happens in any cycle where valid && ready; the
  // sender holds its payload stable while valid is high and ready is low.

  pe_ctrl_state_t state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] issued_q, issued_d;
  logic [LEN_WIDTH-1:0] retired_q, retired_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [PE_LANES-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [WEIGHT_WIDTH-1:0] weight_q, weight_d;

  logic issue;
  logic retire;
  logic signed [RESULT_WIDTH-1:0] result_s;

  assign result_s = pe.result_out;

  pe_valid_pipe #(.DEPTH(PE_LATENCY + 1)) u_valid_pipe (
    .clk    (clk),
    .rst    (rst),
    .issue  (issue),
    .retire (retire)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    issued_d  = issued_q;
    retired_d = retired_q;
    acc_d     = acc_q;
    data_d    = data_q;
    weight_d  = weight_q;

    src_ready = (state_q == FEED) && (issued_q != len_q);
    issue     = src_ready && src_valid;

    if (issue) begin
      data_d   = src_data;
      weight_d = src_weight;
      issued_d = issued_q + 1'b1;
    end

    // Accumulation wraps; the PE result is sign-extended to the accumulator width.
    if (retire && (state_q == FEED || state_q == DRAIN)) begin
      acc_d     = acc_q + ACC_WIDTH'(result_s);
      retired_d = retired_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d     = len;
          issued_d  = '0;
          retired_d = '0;
          acc_d     = '0;
          state_d   = (len == '0) ? OUT : FEED;
        end
      end
      FEED: begin
        if (issue && issued_d == len_q) state_d = DRAIN;
      end
      DRAIN: begin
        // Uses the post-retire count so OUT follows the final retire directly.
        if (retired_d == len_q) state_d = OUT;
      end
      OUT: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      issued_q  <= '0;
      retired_q <= '0;
      acc_q     <= '0;
      data_q    <= '0;
      weight_q  <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      issued_q  <= issued_d;
      retired_q <= retired_d;
      acc_q     <= acc_d;
      data_q    <= data_d;
      weight_q  <= weight_d;
    end
  end

  assign pe.data_in   = data_q;
  assign pe.weight_in = weight_q;
  assign busy         = (state_q != IDLE);
  assign res_valid    = (state_q == OUT);
  assign res_data     = acc_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Self-checking bench for pe_seq_ctrl: a 24-bit and a 17-bit accumulator instance run in lockstep.
module tb_pe_seq_ctrl;
  import pe_ctrl_pkg::*;

  localparam int L = 1;

  logic clk = 1'b0;
  logic rst, start, src_valid, res_ready;
  logic [7:0] len;
  logic [3:0][15:0] src_data;
  logic [3:0] src_weight;
  logic busy, src_ready, res_valid;
  logic [23:0] res_data;
  pe_ctrl_state_t state_dbg;
  logic busy_w, src_ready_w, res_valid_w;
  logic [16:0] res_data_w;
  pe_ctrl_state_t state_dbg_w;

  logic [3:0][15:0] bd [256];
  logic [3:0]       bw [256];
  int errors = 0;
  int checks = 0;

  PE_data_if pe_a ();
  PE_data_if pe_b ();

  always #5 clk = ~clk;

  pe_seq_ctrl #(.ACC_WIDTH(24), .PE_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .src_weight(src_weight), .pe(pe_a), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .state_dbg(state_dbg)
  );

  pe_seq_ctrl #(.ACC_WIDTH(17), .PE_LATENCY(L)) dut_w (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy_w),
    .src_valid(src_valid), .src_ready(src_ready_w), .src_data(src_data),
    .src_weight(src_weight), .pe(pe_b), .res_valid(res_valid_w),
    .res_ready(res_ready), .res_data(res_data_w), .state_dbg(state_dbg_w)
  );

  // Stand-in PE: lane0 + lane1 * weight (all signed), one register of latency.
  function automatic logic [15:0] pe_fn(input logic [3:0][15:0] d, input logic [3:0] w);
    int a, b, c;
    a = $signed(d[0]);
    b = $signed(d[1]);
    c = $signed(w);
    return 16'(a + b * c);
  endfunction

  always @(posedge clk) begin
    pe_a.result_out <= pe_fn(pe_a.data_in, pe_a.weight_in);
    pe_b.result_out <= pe_fn(pe_b.data_in, pe_b.weight_in);
  end

  function automatic longint model_sum(input int n);
    longint s;
    logic signed [15:0] r;
    s = 0;
    for (int i = 0; i < n; i++) begin
      r = pe_fn(bd[i], bw[i]);
      s += longint'(r);
    end
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; src_valid = 1'b0; res_ready = 1'b0;
    len = '0; src_data = '0; src_weight = '0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      bd[i] = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      bw[i] = 4'($urandom);
    end
  endtask

  // Runs one job from IDLE and reports what was observed; mode 0 valid always,
  // 1 valid on alternate cycles, 2 random valid.
  task automatic do_job(input int n, input int mode, input int hold_cycles, input bit poke,
                        output logic [23:0] got, output logic [16:0] got_w, output int n_iss,
                        output int lat, output int hold_err, output int rdy_cnt,
                        output bit busy1, output bit busy_after, output bit tmo);
    int cyc, acc_cyc, idx;
    logic [3:0][15:0] last;
    bit done;
    n_iss = 0; lat = -1; hold_err = 0; rdy_cnt = 0; tmo = 0; busy1 = 0; busy_after = 1;
    got = '0; got_w = '0; last = '0; done = 0; acc_cyc = 0;
    start = 1'b1; len = 8'(n);
    step();
    start = 1'b0; len = 8'($urandom_range(0, 255)); cyc = 1;
    busy1 = busy;
    while (!done) begin
      if (cyc > 3000) begin
        tmo = 1;
        done = 1;
      end else begin
        if (n_iss > 0 && pe_a.data_in !== last) hold_err++;
        if (src_ready === 1'b1) rdy_cnt++;
        case (mode)
          0:       src_valid = 1'b1;
          1:       src_valid = (cyc % 2 == 1);
          default: src_valid = 1'($urandom_range(0, 1));
        endcase
        idx = (n_iss < 256) ? n_iss : 255;
        src_data = bd[idx];
        src_weight = bw[idx];
        start = (poke && cyc == 2);
        if (poke && cyc == 2) len = 8'd7;
        if (src_valid && src_ready === 1'b1) begin
          n_iss++;
          last = src_data;
          acc_cyc = cyc;
        end
        if (res_valid === 1'b1) begin
          src_valid = 1'b0; start = 1'b0;
          got = res_data; got_w = res_data_w; lat = cyc - acc_cyc;
          res_ready = 1'b0;
          for (int i = 0; i < hold_cycles; i++) begin
            step();
            if (res_valid !== 1'b1 || res_data !== got) hold_err++;
          end
          res_ready = 1'b1;
          if (poke) begin start = 1'b1; len = 8'd1; end
          step();
          res_ready = 1'b0; start = 1'b0;
          busy_after = busy;
          done = 1;
        end else begin
          step();
          cyc++;
        end
      end
    end
    src_valid = 1'b0; start = 1'b0; res_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (src_ready !== 1'b0) begin errors++; $display("FAIL rst_src_ready: got %b expected 0", src_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid: got %b expected 0", res_valid); end
    checks++; if (res_data !== 24'd0) begin errors++; $display("FAIL rst_res_data: got %h expected 0", res_data); end
    checks++; if (pe_a.data_in !== 64'd0) begin errors++; $display("FAIL rst_data_in: got %h expected 0", pe_a.data_in); end
    checks++; if (pe_a.weight_in !== 4'd0) begin errors++; $display("FAIL rst_weight_in: got %h expected 0", pe_a.weight_in); end
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL rst_state: got %0d expected IDLE", state_dbg); end
  endtask

  task automatic test_len3();
    logic [23:0] got; logic [16:0] got_w; int n_iss, lat, herr, rcnt; bit b1, ba, tmo;
    bd[0] = '0; bd[1] = '0; bd[2] = '0;
    bd[0][0] = 16'd5; bd[1][0] = 16'hFFFE; bd[2][0] = 16'd100;
    bw[0] = 4'd3; bw[1] = 4'd9; bw[2] = 4'd1;
    do_reset();
    do_job(3, 0, 0, 0, got, got_w, n_iss, lat, herr, rcnt, b1, ba, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL len3_timeout: no result within budget"); end
    checks++; if (got !== 24'd103) begin errors++; $display("FAIL len3_sum: got %0d expected 103", $signed(got)); end
    checks++; if (got_w !== 17'd103) begin errors++; $display("FAIL len3_sum_w17: got %0d expected 103", got_w); end
    checks++; if (n_iss != 3) begin errors++; $display("FAIL len3_beats: got %0d expected 3", n_iss); end
    checks++; if (rcnt != 3) begin errors++; $display("FAIL len3_ready_cycles: got %0d expected 3", rcnt); end
    checks++; if (lat != 2 + L) begin errors++; $display("FAIL len3_latency: got %0d expected %0d", lat, 2 + L); end
    checks++; if (!b1) begin errors++; $display("FAIL len3_busy_start: got 0 expected 1"); end
    checks++; if (ba) begin errors++; $display("FAIL len3_busy_after: got 1 expected 0"); end
  endtask

  task automatic test_gaps();
    logic [23:0] got; logic [16:0] got_w; int n_iss, lat, herr, rcnt; bit b1, ba, tmo;
    longint s;
    fill_random(4);
    s = model_sum(4);
    do_job(4, 1, 0, 0, got, got_w, n_iss, lat, herr, rcnt, b1, ba, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL gaps_timeout: no result within budget"); end
    checks++; if (got !== 24'(s)) begin errors++; $display("FAIL gaps_sum: got %h expected %h", got, 24'(s)); end
    checks++; if (n_iss != 4) begin errors++; $display("FAIL gaps_beats: got %0d expected 4", n_iss); end
    checks++; if (herr != 0) begin errors++; $display("FAIL gaps_data_hold: got %0d changes expected 0", herr); end
    checks++; if (lat != 2 + L) begin errors++; $display("FAIL gaps_latency: got %0d expected %0d", lat, 2 + L); end
  endtask

  task automatic test_len0();
    logic [23:0] got; logic [16:0] got_w; int n_iss, lat, herr, rcnt; bit b1, ba, tmo;
    do_job(0, 0, 5, 0, got, got_w, n_iss, lat, herr, rcnt, b1, ba, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL len0_timeout: no result within budget"); end
    checks++; if (got !== 24'd0) begin errors++; $display("FAIL len0_sum: got %h expected 0", got); end
    checks++; if (lat != 1) begin errors++; $display("FAIL len0_latency: got %0d expected 1", lat); end
    checks++; if (herr != 0) begin errors++; $display("FAIL len0_hold: got %0d unstable cycles expected 0", herr); end
    checks++; if (n_iss != 0) begin errors++; $display("FAIL len0_beats: got %0d expected 0", n_iss); end
  endtask

  task automatic test_overflow();
    logic [23:0] got; logic [16:0] got_w; int n_iss, lat, herr, rcnt; bit b1, ba, tmo;
    longint s;
    for (int i = 0; i < 200; i++) begin
      bd[i] = '0; bd[i][0] = 16'h7FFF; bw[i] = 4'($urandom);
    end
    s = 200 * 32767;
    do_job(200, 0, 0, 0, got, got_w, n_iss, lat, herr, rcnt, b1, ba, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL ovf_timeout: no result within budget"); end
    checks++; if (got !== 24'd6553400) begin errors++; $display("FAIL ovf_sum24: got %0d expected 6553400", got); end
    checks++; if (got_w !== 17'(s)) begin errors++; $display("FAIL ovf_sum17: got %h expected %h", got_w, 17'(s)); end
    checks++; if (rcnt != 200) begin errors++; $display("FAIL ovf_ready_cycles: got %0d expected 200", rcnt); end
  endtask

  task automatic test_start_ignored();
    logic [23:0] got; logic [16:0] got_w; int n_iss, lat, herr, rcnt; bit b1, ba, tmo;
    longint s;
    fill_random(5);
    s = model_sum(5);
    do_job(5, 0, 1, 1, got, got_w, n_iss, lat, herr, rcnt, b1, ba, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL poke_timeout: no result within budget"); end
    checks++; if (n_iss != 5) begin errors++; $display("FAIL poke_beats: got %0d expected 5", n_iss); end
    checks++; if (got !== 24'(s)) begin errors++; $display("FAIL poke_sum: got %h expected %h", got, 24'(s)); end
    checks++; if (ba) begin errors++; $display("FAIL poke_busy_after: got 1 expected 0"); end
  endtask

  task automatic test_reset_out();
    logic [23:0] got; logic [16:0] got_w; int n_iss, lat, herr, rcnt; bit b1, ba, tmo;
    int cyc;
    fill_random(2);
    start = 1'b1; len = 8'd2; src_valid = 1'b1; src_data = bd[0]; src_weight = bw[0];
    step();
    start = 1'b0; cyc = 0;
    while (res_valid !== 1'b1 && cyc < 50) begin
      src_data = bd[1]; src_weight = bw[1];
      step(); cyc++;
    end
    src_valid = 1'b0;
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL rout_reach_out: got %b expected 1", res_valid); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rout_res_valid: got %b expected 0", res_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rout_busy: got %b expected 0", busy); end
    bd[0] = '0; bd[0][0] = 16'd42; bw[0] = 4'd0;
    do_job(1, 0, 0, 0, got, got_w, n_iss, lat, herr, rcnt, b1, ba, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL rout_timeout: no result within budget"); end
    checks++; if (got !== 24'd42) begin errors++; $display("FAIL rout_next_sum: got %0d expected 42", got); end
  endtask

  task automatic test_random();
    logic [23:0] got; logic [16:0] got_w; int n_iss, lat, herr, rcnt; bit b1, ba, tmo;
    longint s;
    int n;
    for (int j = 0; j < 10; j++) begin
      n = $urandom_range(0, 20);
      fill_random(n);
      s = model_sum(n);
      do_job(n, 2, $urandom_range(0, 3), 0, got, got_w, n_iss, lat, herr, rcnt, b1, ba, tmo);
      checks++; if (tmo) begin errors++; $display("FAIL rnd_timeout: job %0d no result", j); end
      checks++; if (got !== 24'(s)) begin errors++; $display("FAIL rnd_sum: job %0d got %h expected %h", j, got, 24'(s)); end
      checks++; if (got_w !== 17'(s)) begin errors++; $display("FAIL rnd_sum_w17: job %0d got %h expected %h", j, got_w, 17'(s)); end
      checks++; if (n_iss != n) begin errors++; $display("FAIL rnd_beats: job %0d got %0d expected %0d", j, n_iss, n); end
      checks++; if (lat != ((n == 0) ? 1 : 2 + L)) begin errors++; $display("FAIL rnd_latency: job %0d got %0d expected %0d", j, lat, (n == 0) ? 1 : 2 + L); end
      checks++; if (herr != 0) begin errors++; $display("FAIL rnd_hold: job %0d got %0d unstable cycles expected 0", j, herr); end
      checks++; if (ba) begin errors++; $display("FAIL rnd_busy_after: job %0d got 1 expected 0", j); end
    end
  endtask

  initial begin
    test_reset();
    test_len3();
    test_gaps();
    test_len0();
    test_overflow();
    test_start_ignored();
    test_reset_out();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
